n_term_cfg_pipe: RTL

Parametrised north-edge terminal tile for the eFPGA fabric. It forwards the configuration frame bus (FrameData/FrameStrobe) down the column through an optional register pipeline. It also returns north-arriving wires back south through a configurable loopback. The loopback is controlled by config bits captured from one frame strobe. It replaces the fixed-width, unregistered, purely combinational terminal tile where long columns need retiming and per-wire loopback masking.

---
 rtl/n_term_cfg_pipe.sv | 97 +++++++++
 1 files changed

// File: rtl/n_term_cfg_pipe.sv
// North-edge terminal tile: retimed configuration frame pass-through plus
// a per-wire maskable N-to-S loopback whose enables and mode come from a
// config word captured on the rising edge of one frame strobe.
module n_term_cfg_pipe #(
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned PIPE_STAGES     = 1,
  parameter int unsigned LOOP_WIDTH      = 24,
  parameter int unsigned CFG_FRAME       = 0
) (
  input  logic                       UserCLK,
  input  logic                       RST,
  input  logic [FrameBitsPerRow-1:0] FrameData,
  input  logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic [FrameBitsPerRow-1:0] FrameData_O,
  output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
  input  logic [LOOP_WIDTH-1:0]      N_END,
  output logic [LOOP_WIDTH-1:0]      S_BEG,
  output logic [7:0]                 CfgWriteCount
);

  // Illegal parameter combinations stop elaboration.
  if (PIPE_STAGES > 3) begin : g_bad_pipe
    $error("n_term_cfg_pipe: PIPE_STAGES must be in 0..3");
  end
  if (LOOP_WIDTH + 1 > FrameBitsPerRow) begin : g_bad_loop
    $error("n_term_cfg_pipe: LOOP_WIDTH+1 must not exceed FrameBitsPerRow");
  end
  if (CFG_FRAME >= MaxFramesPerCol) begin : g_bad_frame
    $error("n_term_cfg_pipe: CFG_FRAME must be below MaxFramesPerCol");
  end

  // Frame bus: either a straight wire or a reset-clearable shift pipeline.
  if (PIPE_STAGES == 0) begin : g_comb
    assign FrameData_O   = FrameData;
    assign FrameStrobe_O = FrameStrobe;
  end else begin : g_pipe
    logic [FrameBitsPerRow-1:0] data_q   [PIPE_STAGES];
    logic [MaxFramesPerCol-1:0] strobe_q [PIPE_STAGES];

    // Shift data and strobe together so their alignment is preserved.
    always_ff @(posedge UserCLK or posedge RST) begin
      if (RST) begin
        for (int unsigned i = 0; i < PIPE_STAGES; i++) begin
          data_q[i]   <= '0;
          strobe_q[i] <= '0;
        end
      end else begin
        data_q[0]   <= FrameData;
        strobe_q[0] <= FrameStrobe;
        for (int unsigned i = 1; i < PIPE_STAGES; i++) begin
          data_q[i]   <= data_q[i-1];
          strobe_q[i] <= strobe_q[i-1];
        end
      end
    end

    assign FrameData_O   = data_q[PIPE_STAGES-1];
    assign FrameStrobe_O = strobe_q[PIPE_STAGES-1];
  end

  logic [LOOP_WIDTH-1:0] cfg_en;
  logic                  cfg_reg_mode;
  logic                  strobe_prev;
  logic [LOOP_WIDTH-1:0] N_q;
  logic                  capture;

  // Capture only on the first cycle of a high strobe, using the un-delayed bus.
  assign capture = FrameStrobe[CFG_FRAME] & ~strobe_prev;

  // Config capture, saturating write counter and the loopback retiming register.
  always_ff @(posedge UserCLK or posedge RST) begin
    if (RST) begin
      cfg_en        <= '0;
      cfg_reg_mode  <= 1'b0;
      strobe_prev   <= 1'b0;
      N_q           <= '0;
      CfgWriteCount <= '0;
    end else begin
      strobe_prev <= FrameStrobe[CFG_FRAME];
      N_q         <= N_END;
      if (capture) begin
        cfg_en       <= FrameData[LOOP_WIDTH-1:0];
        cfg_reg_mode <= FrameData[LOOP_WIDTH];
        if (CfgWriteCount != 8'hFF) begin
          CfgWriteCount <= CfgWriteCount + 8'd1;
        end
      end
    end
  end

  // Masked loopback, either straight through or from last cycle's sample.
  always_comb begin
    S_BEG = cfg_en & (cfg_reg_mode ? N_q : N_END);
  end

endmodule
